// File: rtl/pipeline_swap_sequencer.sv
// Hands output over between two DSP pipelines with a linear crossfade,
// and holds back pipeline resets that arrive while the fade is running.
module pipeline_swap_sequencer #(
   parameter int unsigned DATA_WIDTH   = 16,
   parameter int unsigned FADE_SAMPLES = 256
) (
   input  logic                         clk,
   input  logic                         reset,
   input  logic                         sample_tick,
   input  logic signed [DATA_WIDTH-1:0] sample_in_0,
   input  logic signed [DATA_WIDTH-1:0] sample_in_1,
   input  logic                         swap_req,
   input  logic [1:0]                   reset_req,
   output logic                         pipelines_swapping,
   output logic                         active_pipeline,
   output logic [1:0]                   reset_pipeline,
   output logic signed [DATA_WIDTH-1:0] sample_out,
   output logic                         sample_out_valid
);

   localparam int unsigned FADE_BITS = $clog2(FADE_SAMPLES);
   localparam int unsigned CTR_W     = FADE_BITS + 1;
   localparam int unsigned SHIFT     = DATA_WIDTH - 1 - FADE_BITS;
   localparam int unsigned PROD_W    = 2 * DATA_WIDTH + 1;

   localparam logic signed [DATA_WIDTH-1:0] UNITY    = {1'b0, {(DATA_WIDTH-1){1'b1}}};
   localparam logic signed [DATA_WIDTH-1:0] MIN_VAL  = {1'b1, {(DATA_WIDTH-1){1'b0}}};
   localparam logic signed [PROD_W-1:0]     SAT_MAX  = PROD_W'(UNITY);
   localparam logic signed [PROD_W-1:0]     SAT_MIN  = PROD_W'(MIN_VAL);

   typedef enum logic [2:0] {
      S_IDLE,
      S_ARM,
      S_FADE,
      S_FLIP,
      S_RELEASE
   } state_e;

   state_e                         state_q;
   logic [CTR_W-1:0]               fade_ctr_q;
   logic [CTR_W-1:0]               fade_ctr_d;
   logic [1:0]                     pending_q;
   logic                           active_q;
   logic                           swapping_q;
   logic [1:0]                     reset_pipe_q;
   logic signed [DATA_WIDTH-1:0]   sample_out_q;
   logic                           valid_q;

   logic signed [DATA_WIDTH-1:0]   gain_new_c;
   logic signed [DATA_WIDTH-1:0]   gain_old_c;
   logic signed [DATA_WIDTH-1:0]   old_c;
   logic signed [DATA_WIDTH-1:0]   new_c;
   logic signed [DATA_WIDTH-1:0]   pass_c;
   logic signed [DATA_WIDTH-1:0]   mix_c;
   logic signed [PROD_W-1:0]       acc_c;
   logic signed [PROD_W-1:0]       shifted_c;
   logic                           fading_c;
   logic                           pass_sel_c;

   // Crossfade datapath: old = active pipeline, new = the other one.
   always_comb begin
      fade_ctr_d = fade_ctr_q + CTR_W'(1);
      gain_new_c = DATA_WIDTH'(fade_ctr_q) << SHIFT;
      gain_old_c = UNITY - gain_new_c;
      old_c      = active_q ? sample_in_1 : sample_in_0;
      new_c      = active_q ? sample_in_0 : sample_in_1;
      acc_c      = PROD_W'(old_c) * PROD_W'(gain_old_c)
                 + PROD_W'(new_c) * PROD_W'(gain_new_c);
      shifted_c  = acc_c >>> (DATA_WIDTH - 1);
      mix_c      = DATA_WIDTH'(shifted_c);
      if (shifted_c > SAT_MAX) begin
         mix_c = UNITY;
      end else if (shifted_c < SAT_MIN) begin
         mix_c = MIN_VAL;
      end
   end

   // A tick landing in FLIP already sees the toggled pipeline.
   always_comb begin
      fading_c   = (state_q == S_ARM) || (state_q == S_FADE);
      pass_sel_c = active_q ^ (state_q == S_FLIP);
      pass_c     = pass_sel_c ? sample_in_1 : sample_in_0;
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q      <= S_IDLE;
         fade_ctr_q   <= '0;
         pending_q    <= '0;
         active_q     <= 1'b0;
         swapping_q   <= 1'b0;
         reset_pipe_q <= '0;
         sample_out_q <= '0;
         valid_q      <= 1'b0;
      end else begin
         valid_q      <= sample_tick;
         reset_pipe_q <= '0;
         if (sample_tick) begin
            sample_out_q <= fading_c ? mix_c : pass_c;
         end

         case (state_q)
            S_IDLE: begin
               reset_pipe_q <= reset_req;
               if (swap_req) begin
                  state_q    <= S_ARM;
                  swapping_q <= 1'b1;
                  fade_ctr_q <= '0;
               end
            end
            S_ARM: begin
               reset_pipe_q <= reset_req;
               if (sample_tick) begin
                  fade_ctr_q <= fade_ctr_d;
                  state_q    <= S_FADE;
               end
            end
            S_FADE: begin
               pending_q <= pending_q | reset_req;
               if (sample_tick) begin
                  fade_ctr_q <= fade_ctr_d;
                  if (fade_ctr_d == CTR_W'(FADE_SAMPLES)) begin
                     state_q <= S_FLIP;
                  end
               end
            end
            S_FLIP: begin
               pending_q <= pending_q | reset_req;
               active_q  <= ~active_q;
               state_q   <= S_RELEASE;
            end
            S_RELEASE: begin
               // A reset arriving in this last cycle rides out with the deferred ones.
               reset_pipe_q <= pending_q | reset_req;
               pending_q    <= '0;
               swapping_q   <= 1'b0;
               state_q      <= S_IDLE;
            end
            default: begin
               state_q <= S_IDLE;
            end
         endcase
      end
   end

   assign pipelines_swapping = swapping_q;
   assign active_pipeline    = active_q;
   assign reset_pipeline     = reset_pipe_q;
   assign sample_out         = sample_out_q;
   assign sample_out_valid   = valid_q;

endmodule

// File: tb/tb_pipeline_swap_sequencer.sv
// Bench for pipeline_swap_sequencer: literal vectors, corner sequences and
// randomized traffic against a transaction-level crossfade model.
module tb_pipeline_swap_sequencer;

   localparam int unsigned DW    = 16;
   localparam int unsigned F     = 4;
   localparam int          SHIFT = DW - 1 - 2;
   localparam longint      UNITY = (64'sd1 <<< (DW - 1)) - 1;

   logic          clk;
   logic          reset;
   logic          sample_tick;
   logic [DW-1:0] sample_in_0;
   logic [DW-1:0] sample_in_1;
   logic          swap_req;
   logic [1:0]    reset_req;
   logic          pipelines_swapping;
   logic          active_pipeline;
   logic [1:0]    reset_pipeline;
   logic [DW-1:0] sample_out;
   logic          sample_out_valid;

   int n_tests = 0;
   int n_fail  = 0;

   // Model view: is a swap in progress, how many fade ticks are done,
   // and how many cycles have elapsed since the last fade tick.
   logic          m_swapping;
   logic          m_active;
   logic [1:0]    m_rp;
   logic [DW-1:0] m_out;
   logic          m_valid;
   logic [1:0]    m_pending;
   int            m_ticks;
   int            m_tail;

   pipeline_swap_sequencer #(.DATA_WIDTH(DW), .FADE_SAMPLES(F)) dut (
      .clk                (clk),
      .reset              (reset),
      .sample_tick        (sample_tick),
      .sample_in_0        (sample_in_0),
      .sample_in_1        (sample_in_1),
      .swap_req           (swap_req),
      .reset_req          (reset_req),
      .pipelines_swapping (pipelines_swapping),
      .active_pipeline    (active_pipeline),
      .reset_pipeline     (reset_pipeline),
      .sample_out         (sample_out),
      .sample_out_valid   (sample_out_valid)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #1000000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog");
   end

   function automatic logic [DW-1:0] mix(input logic [DW-1:0] o, input logic [DW-1:0] n,
                                         input int k);
      longint g_new;
      longint g_old;
      longint acc;
      g_new = longint'(k) * (64'sd1 <<< SHIFT);
      g_old = UNITY - g_new;
      acc   = longint'($signed(o)) * g_old + longint'($signed(n)) * g_new;
      acc   = acc >>> (DW - 1);
      if (acc > UNITY) acc = UNITY;
      if (acc < -(UNITY + 1)) acc = -(UNITY + 1);
      return DW'(acc);
   endfunction

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic check_near(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
      int d;
      d = int'($signed(act)) - int'($signed(exp));
      n_tests++;
      if (d < -1 || d > 1) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h (+/-1) at %0t", name, act, exp, $time);
      end
   endtask

   task automatic model_step(input logic tk, input logic sw, input logic [1:0] rr,
                             input logic [DW-1:0] a, input logic [DW-1:0] b, input logic rs);
      if (rs) begin
         m_swapping = 1'b0; m_active = 1'b0; m_rp = '0; m_out = '0; m_valid = 1'b0;
         m_pending = '0; m_ticks = 0; m_tail = 0;
      end else begin
         m_valid = tk;
         m_rp    = '0;
         if (!m_swapping) begin
            if (tk) m_out = m_active ? b : a;
            m_rp = rr;
            if (sw) begin
               m_swapping = 1'b1; m_ticks = 0; m_tail = 0;
            end
         end else if (m_ticks < int'(F)) begin
            if (m_ticks == 0) m_rp = rr;
            else m_pending = m_pending | rr;
            if (tk) begin
               m_out = m_active ? mix(b, a, m_ticks) : mix(a, b, m_ticks);
               m_ticks++;
            end
         end else if (m_tail == 0) begin
            m_pending = m_pending | rr;
            m_active  = ~m_active;
            if (tk) m_out = m_active ? b : a;
            m_tail = 1;
         end else begin
            if (tk) m_out = m_active ? b : a;
            m_rp       = m_pending | rr;
            m_pending  = '0;
            m_swapping = 1'b0;
         end
      end
   endtask

   // One clock: drive at negedge, advance model, compare all outputs after the edge.
   task automatic step(input logic tk, input logic sw, input logic [1:0] rr,
                       input logic [DW-1:0] a, input logic [DW-1:0] b, input logic rs);
      @(negedge clk);
      sample_tick = tk; swap_req = sw; reset_req = rr;
      sample_in_0 = a; sample_in_1 = b; reset = rs;
      model_step(tk, sw, rr, a, b, rs);
      @(posedge clk);
      #1;
      check("sample_out", 32'(sample_out), 32'(m_out));
      check("sample_out_valid", 32'(sample_out_valid), 32'(m_valid));
      check("pipelines_swapping", 32'(pipelines_swapping), 32'(m_swapping));
      check("active_pipeline", 32'(active_pipeline), 32'(m_active));
      check("reset_pipeline", 32'(reset_pipeline), 32'(m_rp));
   endtask

   typedef struct {
      logic [DW-1:0] s0;
      logic [DW-1:0] s1;
      logic [DW-1:0] exp;
   } vec_t;

   vec_t vecs[5];

   logic [DW-1:0] fade_exp[4];

   initial begin
      vecs[0] = '{16'h1234, 16'h7000, 16'h1234};
      vecs[1] = '{16'h8000, 16'h7FFF, 16'h8000};
      vecs[2] = '{16'h7FFF, 16'h0000, 16'h7FFF};
      vecs[3] = '{16'hFFFF, 16'h0001, 16'hFFFF};
      vecs[4] = '{16'h0000, 16'hABCD, 16'h0000};

      reset = 1'b1; sample_tick = 1'b0; swap_req = 1'b0; reset_req = '0;
      sample_in_0 = '0; sample_in_1 = '0;
      m_swapping = 1'b0; m_active = 1'b0; m_rp = '0; m_out = '0; m_valid = 1'b0;
      m_pending = '0; m_ticks = 0; m_tail = 0;

      // Reset and straight pass-through in IDLE
      step(0, 0, 2'b00, 16'h0, 16'h0, 1);
      check("reset_out", 32'(sample_out), 32'h0);
      check("reset_active", 32'(active_pipeline), 32'h0);
      for (int i = 0; i < 5; i++) begin
         step(1, 0, 2'b00, vecs[i].s0, vecs[i].s1, 0);
         check("idle_pass", 32'(sample_out), 32'(vecs[i].exp));
         check("idle_valid", 32'(sample_out_valid), 32'h1);
         check("idle_active", 32'(active_pipeline), 32'h0);
      end
      step(0, 0, 2'b00, 16'h1234, 16'h7000, 0);
      check("valid_one_cycle", 32'(sample_out_valid), 32'h0);

      // Equal inputs through a full fade
      step(1, 1, 2'b00, 16'h4000, 16'h4000, 0);
      check("swapping_rise", 32'(pipelines_swapping), 32'h1);
      for (int i = 0; i < 4; i++) begin
         step(1, 0, 2'b00, 16'h4000, 16'h4000, 0);
         check_near("fade_equal", sample_out, 16'h3FFF);
      end
      check("active_before_flip", 32'(active_pipeline), 32'h0);
      step(0, 0, 2'b00, 16'h4000, 16'h4000, 0);
      check("active_flipped", 32'(active_pipeline), 32'h1);
      check("swapping_in_release", 32'(pipelines_swapping), 32'h1);
      step(0, 0, 2'b00, 16'h4000, 16'h4000, 0);
      check("swapping_fall", 32'(pipelines_swapping), 32'h0);

      // Fade from full scale to silence
      step(0, 0, 2'b00, 16'h0, 16'h0, 1);
      fade_exp[0] = 16'h7FFE; fade_exp[1] = 16'h5FFF;
      fade_exp[2] = 16'h3FFF; fade_exp[3] = 16'h1FFF;
      step(0, 1, 2'b00, 16'h7FFF, 16'h0000, 0);
      for (int i = 0; i < 4; i++) begin
         step(1, 0, 2'b00, 16'h7FFF, 16'h0000, 0);
         check_near("fade_down", sample_out, fade_exp[i]);
      end
      step(0, 0, 2'b00, 16'h7FFF, 16'h0000, 0);
      step(1, 0, 2'b00, 16'h7FFF, 16'h0000, 0);
      check("after_flip_out", 32'(sample_out), 32'h0);

      // Reset request and swap during fade are deferred / ignored
      step(0, 0, 2'b00, 16'h0, 16'h0, 1);
      step(0, 1, 2'b00, 16'h1000, 16'h2000, 0);
      step(1, 0, 2'b00, 16'h1000, 16'h2000, 0);
      step(0, 1, 2'b01, 16'h1000, 16'h2000, 0);
      check("defer_no_fwd", 32'(reset_pipeline), 32'h0);
      for (int i = 0; i < 3; i++) begin
         step(1, 0, 2'b00, 16'h1000, 16'h2000, 0);
         check("defer_fade_rp", 32'(reset_pipeline), 32'h0);
      end
      step(0, 0, 2'b00, 16'h1000, 16'h2000, 0);
      check("defer_flip_rp", 32'(reset_pipeline), 32'h0);
      step(0, 0, 2'b00, 16'h1000, 16'h2000, 0);
      check("defer_release_rp", 32'(reset_pipeline), 32'h1);
      check("no_rearm", 32'(pipelines_swapping), 32'h0);
      step(1, 0, 2'b00, 16'h1000, 16'h2000, 0);
      check("defer_pulse_end", 32'(reset_pipeline), 32'h0);
      check("no_rearm_later", 32'(pipelines_swapping), 32'h0);

      // Reset in the middle of a fade
      step(0, 0, 2'b00, 16'h0, 16'h0, 1);
      step(0, 1, 2'b00, 16'h1111, 16'h2222, 0);
      step(1, 0, 2'b00, 16'h1111, 16'h2222, 0);
      step(1, 0, 2'b00, 16'h1111, 16'h2222, 0);
      step(1, 0, 2'b00, 16'h1111, 16'h2222, 1);
      check("abort_out", 32'(sample_out), 32'h0);
      check("abort_swapping", 32'(pipelines_swapping), 32'h0);
      check("abort_active", 32'(active_pipeline), 32'h0);
      step(1, 0, 2'b00, 16'h1111, 16'h2222, 0);
      check("abort_pass", 32'(sample_out), 32'h1111);

      // Most-negative inputs must not wrap
      step(0, 0, 2'b00, 16'h0, 16'h0, 1);
      step(0, 1, 2'b00, 16'h8000, 16'h8000, 0);
      for (int i = 0; i < 4; i++) begin
         step(1, 0, 2'b00, 16'h8000, 16'h8000, 0);
         check("sat_negative", 32'(sample_out[DW-1]), 32'h1);
      end
      step(0, 0, 2'b00, 16'h8000, 16'h8000, 0);
      step(0, 0, 2'b00, 16'h8000, 16'h8000, 0);

      // Randomized traffic
      for (int c = 0; c < 3000; c++) begin
         logic          tk;
         logic          sw;
         logic [1:0]    rr;
         logic          rs;
         tk = ($urandom_range(0, 2) == 0);
         sw = ($urandom_range(0, 9) == 0);
         rr = ($urandom_range(0, 11) == 0) ? 2'($urandom_range(1, 3)) : 2'b00;
         rs = ($urandom_range(0, 399) == 0);
         step(tk, sw, rr, DW'($urandom), DW'($urandom), rs);
      end

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
